// File: rtl/rom_read_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | rom_read_arbiter_if                                                        |
// | Request/response, ROM-side and statistics signals of rom_read_arbiter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rom_read_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_err;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [DATA_WIDTH-1:0]         rom_data;
    logic [2:0]                    stat_sel;
    logic [15:0]                   stat_count;

    // Arbiter side
    modport slave (
        input  req_valid, req_addr, rom_data, stat_sel,
        output req_ready, resp_valid, resp_data, resp_err, rom_addr, stat_count
    );

    // Requester / ROM / system side
    modport master (
        output req_valid, req_addr, rom_data, stat_sel,
        input  req_ready, resp_valid, resp_data, resp_err, rom_addr, stat_count
    );
endinterface

`default_nettype wire

// File: rtl/rom_read_arbiter.sv
// +----------------------------------------------------------------------------+
// | rom_read_arbiter                                                           |
// | Round-robin, pipelined sharing of one synchronous-read ROM among NUM_REQ   |
// | requesters. Optional grant counters: ROM_READ_ARBITER_STATS_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rom_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_LEN   = 1024
) (
    input  logic              clock,
    input  logic              reset,
    rom_read_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      next_ptr;
    logic [PTR_W:0]        scan_idx;
    logic [PTR_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_err;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [NUM_REQ-1:0]    tag1;
    logic [NUM_REQ-1:0]    tag2;
    logic                  err1;
    logic                  err2;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_any && bus.req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_any                   = 1'b1;
                grant_idx                   = scan_idx[PTR_W-1:0];
                grant[scan_idx[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_err  = (32'(sel_addr) >= DATA_LEN);
        if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            rom_addr_q <= '0;
            tag1       <= '0;
            tag2       <= '0;
            err1       <= 1'b0;
            err2       <= 1'b0;
        end else begin
            if (grant_any) begin
                ptr        <= next_ptr;
                rom_addr_q <= sel_addr;
                tag1       <= grant;
                err1       <= sel_err;
            end else begin
                tag1       <= '0;
                err1       <= 1'b0;
            end
            tag2 <= tag1;
            err2 <= err1;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.resp_valid = tag2;
    assign bus.resp_err   = err2;
    // Out-of-range slots still occupy the pipe, but their ROM data is discarded.
    assign bus.resp_data  = ((|tag2) && !err2) ? bus.rom_data : '0;

`ifdef ROM_READ_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && (grant_cnt[i] != 16'hFFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        bus.stat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.stat_sel == 3'(i)) begin
                bus.stat_count = grant_cnt[i];
            end
        end
    end
`else
    logic stat_sel_unused;
    assign stat_sel_unused = ^bus.stat_sel;
    assign bus.stat_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_rom_read_arbiter                                                        |
// | Scoreboard bench: directed scenarios followed by random traffic.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rom_read_arbiter;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DL = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_LEN(DL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read ROM: data for the previous cycle's address.
    logic [DW-1:0] mem [1024];
    always @(posedge clock) bus.rom_data <= mem[bus.rom_addr];

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [7:0]  data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mptr = 0;
    int          mcnt [NR];
    bit          prev_acc = 1'b0;
    logic [9:0]  prev_addr = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle.
    always @(negedge clock) begin
        int          g;
        int          idx;
        logic [3:0]  exp_ready;
        logic [15:0] exp_stat;
        logic [9:0]  a;
        exp_t        e;
        cyc++;
        if (reset) begin
            sb.delete();
            mptr     = 0;
            prev_acc = 1'b0;
            for (int i = 0; i < NR; i++) mcnt[i] = 0;
            chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
            chk("reset_resp_err",   32'(bus.resp_err),   32'h0);
            chk("reset_resp_data",  32'(bus.resp_data),  32'h0);
            chk("reset_rom_addr",   32'(bus.rom_addr),   32'h0);
            chk("reset_stat_count", 32'(bus.stat_count), 32'h0);
        end else begin
`ifdef ROM_READ_ARBITER_STATS_EN
            exp_stat = (int'(bus.stat_sel) < NR) ? 16'(mcnt[bus.stat_sel]) : 16'h0;
`else
            exp_stat = 16'h0;
`endif
            chk("stat_count", 32'(bus.stat_count), 32'(exp_stat));

            if (prev_acc) chk("rom_addr", 32'(bus.rom_addr), 32'(prev_addr));
            prev_acc = 1'b0;

            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("resp_valid", 32'(bus.resp_valid), 32'(e.tag));
                chk("resp_err",   32'(bus.resp_err),   32'(e.err));
                chk("resp_data",  32'(bus.resp_data),  32'(e.data));
            end else begin
                chk("idle_resp_valid", 32'(bus.resp_valid), 32'h0);
                chk("idle_resp_data",  32'(bus.resp_data),  32'h0);
                chk("idle_resp_err",   32'(bus.resp_err),   32'h0);
            end

            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (mptr + k) % NR;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
            exp_ready = (g < 0) ? 4'h0 : 4'(1 << g);
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));

            if (g >= 0) begin
                a      = bus.req_addr[g*AW +: AW];
                e.due  = cyc + 2;
                e.tag  = exp_ready;
                e.err  = (int'(a) >= DL);
                e.data = e.err ? 8'h00 : mem[a];
                sb.push_back(e);
                mptr = (g + 1) % NR;
                if (mcnt[g] < 65535) mcnt[g]++;
                prev_acc  = 1'b1;
                prev_addr = a;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(logic [3:0] v, int a0, int a1, int a2, int a3);
        bus.req_valid = v;
        bus.req_addr  = {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA7;
        set_req(4'b0000, 0, 0, 0, 0);
        bus.stat_sel = 3'd0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Single request from requester 2
        set_req(4'b0100, 0, 0, 5, 0);
        step();
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (3) step();

        // All four requesters held for 8 cycles
        set_req(4'b1111, 16, 300, 511, 999);
        repeat (8) step();

        // Move ptr to 2, then 1 and 3 compete
        set_req(4'b0010, 0, 77, 0, 0);
        step();
        set_req(4'b1010, 0, 12, 0, 900);
        repeat (4) step();
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (2) step();

        // Out-of-range read
        set_req(4'b0001, 1023, 0, 0, 0);
        step();
        set_req(4'b0001, 1000, 0, 0, 0);
        step();
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (3) step();

        // Reset one cycle after an accept
        set_req(4'b1000, 0, 0, 0, 7);
        step();
        set_req(4'b0000, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) step();
        set_req(4'b1001, 33, 0, 0, 44);
        reset = 1'b0;
        step();
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (3) step();

        // Five grants to requester 1, then statistics reads
        bus.stat_sel = 3'd1;
        set_req(4'b0010, 0, 100, 0, 0);
        repeat (5) step();
        set_req(4'b0000, 0, 0, 0, 0);
        repeat (2) step();
        bus.stat_sel = 3'd5;
        repeat (2) step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            set_req(4'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023));
            bus.stat_sel = 3'($urandom);
            step();
        end

        set_req(4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        chk("drain_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one synchronous-read data ROM (registered address in, one-cycle registered data out, contents loaded from a hex file) among NUM_REQ requesters.
- Round-robin arbitration with valid/ready request handshake; pipelined, one ROM access per cycle.
- Sits between requester blocks (UART message streamer, debug reader, etc.) and the single ROM instance in the top-level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 10, ROM address width.
- DATA_WIDTH, 8, ROM word width.
- DATA_LEN, 1024, ROM depth; addresses >= DATA_LEN are out of range.

Ports:
- clock  in  1  global clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] && req_ready[i].
- resp_valid  out  NUM_REQ  one-hot; response for requester i this cycle.
- resp_data  out  DATA_WIDTH  read data; qualified by resp_valid.
- resp_err  out  1  out-of-range flag; qualified by resp_valid.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM.
- rom_data  in  DATA_WIDTH  ROM registered output: data for the rom_addr of the previous cycle.
- stat_sel  in  3  statistics requester select.
- stat_count  out  16  grant count for stat_sel.

Behaviour:
- Arbitration is combinational each cycle. Priority starts at ptr (0..NUM_REQ-1) and rotates upward with wrap. The first i with req_valid[i] gets req_ready[i]=1; all other bits are 0. With no request, req_ready=0.
- On acceptance of requester g, ptr <= (g+1) mod NUM_REQ. With no acceptance, ptr holds.
- Pipeline stage 1, at the accept edge:
  - rom_addr <= req_addr[g].
  - tag1 <= onehot(g).
  - err1 <= (req_addr[g] >= DATA_LEN).
  - Without an accept: tag1 <= 0 and rom_addr holds.
- Pipeline stage 2, next edge: tag2 <= tag1 and err2 <= err1. The ROM concurrently registers data_[rom_addr].
- Response outputs are combinational from stage 2:
  - resp_valid = tag2.
  - resp_err = err2.
  - resp_data = err2 ? 0 : rom_data.
  - When tag2 = 0, resp_data = 0.
- Latency: accepted in cycle T means response in cycle T+2. Throughput is one access per cycle, with back-to-back accepts from the same or different requesters.
- Responses cannot be back-pressured. A requester may hold at most the accesses it issued and must sink every response.
- Out-of-range requests still consume a grant and a slot. rom_addr is driven but the data is discarded.
- Reset values: ptr=0, rom_addr=0, tag1=tag2=0, err1=err2=0, stat counters=0. Therefore resp_valid=0, resp_err=0, resp_data=0.
- Reset asserted mid-operation: in-flight accesses are dropped, no resp_valid is emitted for them, and arbitration restarts at requester 0 on the first cycle after release.
- req_addr may change while req_valid=0; it is sampled only on accept.
- stat_sel >= NUM_REQ: stat_count=0.

Optional Feature:
- Macro ROM_READ_ARBITER_STATS_EN.
- Defined: one 16-bit grant counter per requester, incremented on each accept of that requester and saturating at 0xFFFF. stat_count = counter[stat_sel], combinational. Counters are cleared by reset.
- Undefined: no counters are built and stat_count is tied to 0. Ports are unchanged.

Test Plan:
- Single request: reset, then requester 2 requests addr 0x005 for one cycle with ROM[5]=0xA7 -> req_ready=4'b0100 that cycle; rom_addr=0x005 next cycle; resp_valid=4'b0100 and resp_data=0xA7 two cycles after accept.
- All four requesters hold req_valid for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3. Responses follow in the same order, one per cycle, each with its own address's data.
- Requesters 1 and 3 continuous, ptr=2 -> grants 3,1,3,1. Requesters 0 and 2 never get req_ready.
- Out of range: requester 0 reads addr 1023 with DATA_LEN=1000 -> resp_valid=4'b0001, resp_err=1, resp_data=0 at T+2.
- Reset asserted one cycle after an accept -> resp_valid stays 0 through and after reset. First post-reset grant goes to requester 0 even when requester 3 also requests.
- With ROM_READ_ARBITER_STATS_EN: 5 grants to requester 1, stat_sel=1 -> stat_count=5; stat_sel=5 -> 0. Without the macro -> stat_count=0 always.
